scrambler_frame_ctrl: RTL and testbench
=======================================

Name: scrambler_frame_ctrl

Overview:
- Frame-level sequencer for the 15-bit PRBS byte scrambler datapath (polynomial 1 + x^14 + x^15).
- Reseeds the LFSR at every frame start and counts bytes per frame.
- Moves bytes between an upstream valid/ready source and a downstream valid/ready sink, one byte per cycle.
- Flags frame start and end on the output, and counts completed frames for status.

Parameters:
- SEED_W, 15, LFSR width; fixed by polynomial, not for override.
- DEFAULT_SEED, 15'h00A9, seed register value after reset.
- FRAME_LEN, 188, bytes per frame; legal range 2..65535.
- CNT_W, 16, width of byte and frame counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- seed_in  in  15  new seed value.
- seed_load  in  1  write seed_in into the seed register this cycle.
- enable  in  1  allow frames to start.
- in_valid  in  1  upstream byte valid.
- in_data  in  8  upstream byte.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- out_valid  out  1  output byte valid.
- out_data  out  8  scrambled byte.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_sof  out  1  qualifies out_data as byte 0 of a frame.
- out_eof  out  1  qualifies out_data as byte FRAME_LEN-1 of a frame.
- busy  out  1  high whenever state != IDLE.
- frame_cnt  out  CNT_W  completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset values:
  - State = IDLE; lfsr = 0; byte_cnt = 0; seed_reg = DEFAULT_SEED.
  - out_valid = 0, out_data = 0, out_sof = 0, out_eof = 0.
  - in_ready = 0, busy = 0, frame_cnt = 0.
  - Reset mid-frame discards the partial frame and any held output byte.
- Seed register: seed_reg <= seed_in on any cycle with seed_load = 1. The new value is used at the next LOAD; a frame in progress is unaffected.
- Byte step (per accepted byte, MSB first, 8 iterations):
  - fb = s[14] ^ s[13]
  - s = {s[13:0], fb}
  - out bit = in bit ^ fb
- FSM states:
  - IDLE: in_ready = 0. Go to LOAD when enable = 1.
  - LOAD: exactly 1 cycle. lfsr <= seed_reg, byte_cnt <= 0, in_ready = 0. Go to RUN.
  - RUN: in_ready = !out_valid || out_ready (single-stage output register, full throughput).
    - On accept: out_data <= step(in_data, lfsr); lfsr <= stepped state; out_valid <= 1; out_sof <= (byte_cnt == 0); out_eof <= (byte_cnt == FRAME_LEN-1); byte_cnt increments.
    - On accepting byte FRAME_LEN-1: frame_cnt increments; next state is LOAD if enable = 1, else IDLE.
- Output register:
  - Latency: input accept to out_valid is 1 cycle.
  - Output is held stable while out_valid && !out_ready.
  - out_valid clears on an output handshake with no simultaneous input accept.
  - The output register drains independently of state, including during LOAD and IDLE.
- enable is sampled only in IDLE and at frame end. Deasserting enable mid-frame still completes the frame.
- Boundary rules:
  - Zero seed gives lfsr stuck at 0: keystream is 0 and data passes unchanged. This is legal and is not flagged.
  - seed_load together with a LOAD cycle: LOAD uses the old seed_reg; the new value applies to the following frame.
  - Back-to-back frames: exactly one bubble (the LOAD cycle) between byte FRAME_LEN-1 and byte 0.

Optional Feature:
- Macro SCRAMBLER_BYPASS_EN.
- Defined: adds input port bypass (1 bit). While bypass = 1, out_data = in_data, but lfsr still advances and framing and counters are unchanged, so keystream alignment is preserved when bypass drops.
- Not defined: no bypass port; data is always scrambled.

Decomposition:
- Package scrambler_pkg holds:
  - SEED_W
  - tap positions (14, 13)
  - DEFAULT_SEED
  - FSM state enum (IDLE, LOAD, RUN)
- Sub-module lfsr_byte_step: purely combinational.
  - Inputs: state[14:0], data[7:0].
  - Outputs: next_state[14:0], data_out[7:0].
  - Shareable with a descrambler controller.

Test Plan (bench uses FRAME_LEN = 4):
- Reset then enable = 1, seed_reg = 15'h6000, input 0x00 -> first out_data = 0x40, lfsr = 15'h0040, out_sof = 1.
- Same seed, input 0xFF -> out_data = 0xBF. seed_load 15'h0000 then a new frame -> out_data equals in_data for all 4 bytes.
- Continuous in_valid with out_ready = 1 -> 4 bytes, 1 LOAD bubble, 4 bytes. out_eof on bytes 3 and 7; frame_cnt = 2; byte 0 of frame 2 is re-scrambled from the seed (0x00 -> 0x40).
- out_ready held 0 for 5 cycles mid-frame -> out_data stable, in_ready = 0, no bytes lost or duplicated.
- enable dropped after byte 1 -> frame completes (out_eof on byte 3), FSM reaches IDLE, busy = 0.
- rst pulsed mid-frame -> all outputs return to reset values within the reset assertion; seed_reg = 15'h00A9.

Source files
------------

// File: rtl/scrambler_pkg.sv
// -----------------------------------------------------------------------------
// scrambler_pkg
//
// Shared definitions for the 15-bit PRBS byte scrambler.
// Polynomial: 1 + x^14 + x^15.
//
// Contents:
//   SEED_W       - LFSR width. It is fixed by the polynomial and must not be
//                  overridden.
//   TAP_HI/LO    - feedback tap positions in the LFSR state.
//   DEFAULT_SEED - value of the seed register after reset.
//   state_t      - frame sequencer FSM states.
// -----------------------------------------------------------------------------
package scrambler_pkg;

   localparam int SEED_W = 15;

   // Feedback is s[TAP_HI] ^ s[TAP_LO] for the x^15 + x^14 terms.
   localparam int TAP_HI = 14;
   localparam int TAP_LO = 13;

   localparam logic [SEED_W-1:0] DEFAULT_SEED = 15'h00A9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

endpackage : scrambler_pkg

// File: rtl/lfsr_byte_step.sv
// -----------------------------------------------------------------------------
// lfsr_byte_step
//
// Purely combinational step of the PRBS scrambler over one byte. Data is
// processed MSB first over 8 bit-iterations. On each iteration:
//   fb       = s[14] ^ s[13]
//   s        = {s[13:0], fb}
//   out bit  = in bit ^ fb
//
// The same block serves a descrambler controller. XOR with the same keystream
// is its own inverse.
//
// Ports:
//   state      in  SEED_W  LFSR state before the byte
//   data       in  8       input byte
//   next_state out SEED_W  LFSR state after 8 iterations
//   data_out   out 8       input byte XOR keystream byte
// -----------------------------------------------------------------------------
module lfsr_byte_step
   import scrambler_pkg::*;
(
   input  logic [SEED_W-1:0] state,
   input  logic [7:0]        data,
   output logic [SEED_W-1:0] next_state,
   output logic [7:0]        data_out
);

   logic [SEED_W-1:0] s;
   logic              fb;

   // Unrolled by the synthesis tool into an 8-deep XOR network. Bit 7 is
   // handled first so that the keystream leads with the MSB.
   always_comb begin
      s        = state;
      fb       = 1'b0;
      data_out = '0;
      for (int i = 7; i >= 0; i--) begin
         fb          = s[TAP_HI] ^ s[TAP_LO];
         s           = {s[SEED_W-2:0], fb};
         data_out[i] = data[i] ^ fb;
      end
      next_state = s;
   end

endmodule : lfsr_byte_step

// File: rtl/scrambler_frame_ctrl.sv
// -----------------------------------------------------------------------------
// scrambler_frame_ctrl
//
// Frame-level sequencer for the 15-bit PRBS byte scrambler. The block does
// the following:
//   - Reseeds the LFSR at every frame start.
//   - Counts bytes per frame.
//   - Moves one byte per cycle from an upstream valid/ready source to a
//     downstream valid/ready sink through a single output register.
//   - Flags the first and last byte of each frame on the output.
//   - Counts completed frames.
//
// Handshake rule, which applies to both interfaces:
//   A transfer happens on a rising clk edge where valid && ready are both high.
//   Once a producer raises valid, it holds valid and data stable until the
//   transfer happens. ready may depend on valid, but valid never depends on
//   ready.
//
// Optional feature:
//   SCRAMBLER_BYPASS_EN is not defined in the default build. When it is
//   defined, the block gains an input port called bypass. While bypass = 1,
//   out_data carries in_data unchanged. The LFSR, the byte counter and the
//   framing keep advancing, so keystream alignment survives when bypass drops.
//
// Parameters:
//   FRAME_LEN  bytes per frame. The legal range is 2..65535.
//   CNT_W      width of the byte counter and the frame counter.
//
// Ports:
//   clk, rst     clock (rising edge) and asynchronous active-high reset.
//   seed_in      new seed value.
//   seed_load    writes seed_in into the seed register. The new seed is used
//                at the next LOAD.
//   enable       allows frames to start. It is sampled only in IDLE and at
//                the end of a frame.
//   in_valid,
//   in_data,
//   in_ready     upstream byte interface.
//   out_valid,
//   out_data,
//   out_ready    downstream byte interface.
//   out_sof,
//   out_eof      qualify out_data as byte 0 or byte FRAME_LEN-1 of a frame.
//   busy         high whenever the FSM is not in IDLE.
//   frame_cnt    completed frames. Wraps modulo 2^CNT_W.
//   bypass       present only with SCRAMBLER_BYPASS_EN. Passes data through
//                unscrambled.
//   dbg_state    current FSM state, encoded as scrambler_pkg::state_t.
// -----------------------------------------------------------------------------
module scrambler_frame_ctrl
   import scrambler_pkg::*;
#(
   parameter int FRAME_LEN = 188,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SEED_W-1:0] seed_in,
   input  logic              seed_load,
   input  logic              enable,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [7:0]        out_data,
   input  logic              out_ready,
   output logic              out_sof,
   output logic              out_eof,
   output logic              busy,
   output logic [CNT_W-1:0]  frame_cnt,
`ifdef SCRAMBLER_BYPASS_EN
   input  logic              bypass,
`endif
   output logic [1:0]        dbg_state
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

   state_t            state_q;
   state_t            state_d;

   logic [SEED_W-1:0] seed_reg_q;
   logic [SEED_W-1:0] lfsr_q;
   logic [SEED_W-1:0] lfsr_step;
   logic [CNT_W-1:0]  byte_cnt_q;
   logic [CNT_W-1:0]  frame_cnt_q;

   logic [7:0]        scr_data;
   logic [7:0]        out_byte;
   logic [7:0]        out_data_q;
   logic              out_valid_q;
   logic              out_sof_q;
   logic              out_eof_q;

   logic              in_ready_c;
   logic              accept;
   logic              last_byte;

   assign accept    = in_valid && in_ready_c;
   assign last_byte = (byte_cnt_q == LAST_IDX);

   // --------------------------------------------------------------------------
   // Keystream step for the byte currently offered upstream.
   // --------------------------------------------------------------------------
   lfsr_byte_step u_step (
      .state      (lfsr_q),
      .data       (in_data),
      .next_state (lfsr_step),
      .data_out   (scr_data)
   );

`ifdef SCRAMBLER_BYPASS_EN
   // Only the data path is muxed. The LFSR still takes lfsr_step on every
   // accept, so the keystream stays aligned with the frame.
   assign out_byte = bypass ? in_data : scr_data;
`else
   assign out_byte = scr_data;
`endif

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next state
   // --------------------------------------------------------------------------
   // enable is looked at only in IDLE and on the last accept of a frame. A
   // frame that has started always runs to completion.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            state_d = RUN;
         end
         RUN: begin
            if (accept && last_byte) begin
               state_d = enable ? LOAD : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM: outputs
   // --------------------------------------------------------------------------
   // In RUN, the single output register can take a new byte in either case:
   //   - it is empty, or
   //   - it is being emptied this same cycle.
   // This gives full throughput without a skid buffer.
   always_comb begin
      in_ready_c = 1'b0;
      busy       = (state_q != IDLE);
      dbg_state  = state_q;
      if (state_q == RUN) begin
         in_ready_c = !out_valid_q || out_ready;
      end
   end

   assign in_ready = in_ready_c;

   // --------------------------------------------------------------------------
   // Seed register
   // --------------------------------------------------------------------------
   // If seed_load coincides with LOAD, LOAD copies the old value because both
   // registers update on the same edge. The new seed lands in the next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seed_reg_q <= DEFAULT_SEED;
      end else if (seed_load) begin
         seed_reg_q <= seed_in;
      end
   end

   // --------------------------------------------------------------------------
   // LFSR, byte counter and frame counter
   // --------------------------------------------------------------------------
   // A zero seed keeps the LFSR at zero, so the keystream is all zeros. This
   // is a legal mode and is not flagged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q      <= '0;
         byte_cnt_q  <= '0;
         frame_cnt_q <= '0;
      end else if (state_q == LOAD) begin
         lfsr_q     <= seed_reg_q;
         byte_cnt_q <= '0;
      end else if (accept) begin
         lfsr_q     <= lfsr_step;
         byte_cnt_q <= byte_cnt_q + CNT_W'(1);
         if (last_byte) begin
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
         end
      end
   end

   assign frame_cnt = frame_cnt_q;

   // --------------------------------------------------------------------------
   // Output register
   // --------------------------------------------------------------------------
   // The output register is not gated by the FSM state. A byte held at frame
   // end therefore drains during LOAD or IDLE.
   //
   // When out_valid drops, out_data, out_sof and out_eof keep their last
   // values. Downstream must qualify them with out_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_data_q  <= out_byte;
         out_sof_q   <= (byte_cnt_q == '0);
         out_eof_q   <= last_byte;
      end else if (out_valid_q && out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sof   = out_sof_q;
   assign out_eof   = out_eof_q;

endmodule : scrambler_frame_ctrl

// File: tb/tb_scrambler_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scrambler_frame_ctrl
//
// Self-checking bench for scrambler_frame_ctrl, built with FRAME_LEN = 4.
//
// Reference model:
//   The keystream is rebuilt from the bit recurrence b[n] = b[n-15] ^ b[n-14].
//   The 15 seed bits form the history, MSB oldest. Byte p of a frame uses
//   bits 8p .. 8p+7 after the history.
//
// Monitor:
//   Records every accepted input byte and every delivered output byte, with
//   its cycle stamp.
//
// Scoreboard:
//   Compares the delivered stream with the model, frame by frame.
// -----------------------------------------------------------------------------
module tb_scrambler_frame_ctrl;

   localparam int FL = 4;

   // ---------------------------------------------------------------- clock/reset
   logic        clk = 1'b0;
   logic        rst;
   logic [14:0] seed_in;
   logic        seed_load;
   logic        enable;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        out_sof;
   logic        out_eof;
   logic        busy;
   logic [15:0] frame_cnt;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   scrambler_frame_ctrl #(.FRAME_LEN(FL), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .seed_in   (seed_in),
      .seed_load (seed_load),
      .enable    (enable),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .out_sof   (out_sof),
      .out_eof   (out_eof),
      .busy      (busy),
      .frame_cnt (frame_cnt),
      .dbg_state (dbg_state)
   );

   // ---------------------------------------------------------------- monitor
   typedef struct {
      logic [7:0] data;
      logic       sof;
      logic       eof;
      int         cyc;
   } cap_t;

   cap_t        cap_q[$];
   logic [7:0]  acc_q[$];
   logic [7:0]  src_q[$];
   logic [7:0]  exp_q[$];
   logic [14:0] fseed_q[$];

   // Sampled on the falling edge. The handshakes seen here complete on the
   // next rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) acc_q.push_back(in_data);
         if (out_valid && out_ready) cap_q.push_back('{out_data, out_sof, out_eof, cyc});
      end
   end

   // ---------------------------------------------------------------- checking
   int n_pass = 0;
   int n_chk  = 0;
   int exp_frames = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [7:0] ks_byte(input logic [14:0] seed, input int pos);
      bit b [0:63];
      logic [7:0] r;
      for (int i = 0; i < 15; i++) b[i] = seed[14-i];
      for (int i = 15; i < 64; i++) b[i] = b[i-15] ^ b[i-14];
      for (int j = 0; j < 8; j++) r[7-j] = b[15 + 8*pos + j];
      return r;
   endfunction

   // Compares the delivered bytes from cap0 on with the accepted bytes from
   // acc0 on. Frame k uses the seed at position k of fseed_q.
   task automatic verify(input string tag, input int acc0, input int cap0);
      int n;
      int pos;
      int fr;
      logic [14:0] sd;
      logic [7:0]  e;
      cap_t c;
      n = acc_q.size() - acc0;
      check({tag, "_count"}, 32'(cap_q.size() - cap0), 32'(n));
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
         pos = k % FL;
         fr  = k / FL;
         sd  = (fr < fseed_q.size()) ? fseed_q[fr] : fseed_q[fseed_q.size()-1];
         exp_q.push_back(acc_q[acc0+k] ^ ks_byte(sd, pos));
      end
      for (int k = 0; k < n; k++) begin
         if (cap0 + k < cap_q.size()) begin
            c = cap_q[cap0+k];
            e = exp_q.pop_front();
            check({tag, "_byte"}, {22'd0, c.sof, c.eof, c.data},
                  {22'd0, (k % FL) == 0, (k % FL) == FL-1, e});
         end
      end
   endtask

   // ---------------------------------------------------------------- drivers
   task automatic load_seed(input logic [14:0] s);
      @(posedge clk); #1;
      seed_in   = s;
      seed_load = 1'b1;
      @(posedge clk); #1;
      seed_load = 1'b0;
   endtask

   // Sends every byte of src_q in order.
   //   drop_at: enable is dropped once this many bytes have been accepted.
   //   rnd:     randomizes in_valid gaps and out_ready.
   task automatic drive(input int drop_at, input bit rnd);
      int n;
      int start;
      int prev;
      int done;
      int guard;
      n     = src_q.size();
      start = acc_q.size();
      prev  = start;
      done  = 0;
      guard = 0;
      in_valid = 1'b0;
      while (guard < 3000) begin
         @(posedge clk); #1;
         done = acc_q.size() - start;
         if (done >= drop_at) enable = 1'b0;
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (done >= n) begin
            in_valid = 1'b0;
            break;
         end
         if (!in_valid || acc_q.size() != prev) begin
            if (!rnd || $urandom_range(0, 3) != 0) begin
               in_valid = 1'b1;
               in_data  = src_q[done];
            end else begin
               in_valid = 1'b0;
            end
         end
         prev = acc_q.size();
         guard++;
      end
      if (guard >= 3000) check("drive_timeout", 32'(done), 32'(n));
   endtask

   task automatic drain();
      int g;
      g = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((out_valid || busy) && g < 100) begin
         @(posedge clk); #1;
         g++;
      end
      check("drain_idle", {30'd0, out_valid, busy}, 32'd0);
      check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic [14:0] seed;
      logic [31:0] din;
      logic [31:0] dout;
   } vec_t;

   vec_t tbl [4];

   initial begin
      int acc0;
      int cap0;
      int g;
      int nf;
      logic [14:0] s;
      cap_t c;

      tbl[0] = '{15'h6000, 32'h00000000, 32'h40018005};
      tbl[1] = '{15'h6000, 32'hFFFFFFFF, 32'hBFFE7FFA};
      tbl[2] = '{15'h0000, 32'hA5C33C5A, 32'hA5C33C5A};
      tbl[3] = '{15'h6000, 32'h12345678, 32'h5235D67D};

      rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      seed_in = '0; seed_load = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", {21'd0, out_valid, out_data, out_sof, out_eof, in_ready, busy}, 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(scrambler_pkg::IDLE));
      rst = 1'b0;

      // Table: one whole frame per record, with known keystream constants.
      for (int t = 0; t < 4; t++) begin
         load_seed(tbl[t].seed);
         enable = 1'b1;
         src_q.delete();
         for (int b = 0; b < 4; b++) src_q.push_back(tbl[t].din[31-8*b -: 8]);
         cap0 = cap_q.size();
         drive(1, 1'b0);
         exp_frames++;
         drain();
         check("tbl_count", 32'(cap_q.size() - cap0), 32'd4);
         for (int b = 0; b < 4; b++) begin
            if (cap0 + b < cap_q.size()) begin
               c = cap_q[cap0+b];
               check("tbl_byte", {22'd0, c.sof, c.eof, c.data},
                     {22'd0, b == 0, b == 3, tbl[t].dout[31-8*b -: 8]});
            end
         end
      end

      // Back-to-back frames: one LOAD bubble, eof on bytes 3 and 7, and a reseed.
      load_seed(15'h6000);
      enable = 1'b1;
      src_q.delete();
      repeat (8) src_q.push_back(8'h00);
      fseed_q = '{15'h6000, 15'h6000};
      acc0 = acc_q.size();
      cap0 = cap_q.size();
      drive(5, 1'b0);
      exp_frames += 2;
      drain();
      verify("b2b", acc0, cap0);
      for (int k = 0; k < 7; k++) begin
         if (cap0 + k + 1 < cap_q.size())
            check("b2b_gap", 32'(cap_q[cap0+k+1].cyc - cap_q[cap0+k].cyc), (k == 3) ? 32'd2 : 32'd1);
      end

      // seed_load in the LOAD cycle: frame 1 uses the old seed, frame 2 the new (zero) one.
      @(posedge clk); #1;
      enable = 1'b1;
      @(posedge clk); #1;
      seed_in = 15'h0000;
      seed_load = 1'b1;
      @(posedge clk); #1;
      seed_load = 1'b0;
      src_q.delete();
      repeat (8) src_q.push_back(8'($urandom));
      fseed_q = '{15'h6000, 15'h0000};
      acc0 = acc_q.size();
      cap0 = cap_q.size();
      drive(5, 1'b0);
      exp_frames += 2;
      drain();
      verify("seedload", acc0, cap0);

      // Output held for 5 cycles mid-frame.
      load_seed(15'h6000);
      enable = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h00;
      out_ready = 1'b1;
      fseed_q = '{15'h6000};
      acc0 = acc_q.size();
      cap0 = cap_q.size();
      g = 0;
      while (cap_q.size() < cap0 + 2 && g < 50) begin
         @(negedge clk); #1;
         g++;
      end
      check("bp_start", 32'(cap_q.size() - cap0), 32'd2);
      @(posedge clk); #1;
      out_ready = 1'b0;
      enable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_hold", {22'd0, out_valid, in_ready, out_data}, {22'd0, 1'b1, 1'b0, 8'h80});
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      g = 0;
      while (acc_q.size() < acc0 + 4 && g < 50) begin
         @(posedge clk); #1;
         g++;
      end
      in_valid = 1'b0;
      exp_frames++;
      drain();
      verify("bp", acc0, cap0);

      // enable dropped after byte 1: the frame completes, then the FSM returns to IDLE.
      enable = 1'b1;
      src_q.delete();
      repeat (4) src_q.push_back(8'($urandom));
      fseed_q = '{15'h6000};
      acc0 = acc_q.size();
      cap0 = cap_q.size();
      drive(2, 1'b0);
      exp_frames++;
      drain();
      verify("endrop", acc0, cap0);
      repeat (3) @(posedge clk);
      #1;
      check("endrop_idle", {30'd0, busy, in_ready}, 32'd0);
      check("endrop_state", 32'(dbg_state), 32'(scrambler_pkg::IDLE));
      check("endrop_nomore", 32'(cap_q.size() - cap0), 32'd4);

      // Randomized segments against the model.
      for (int seg = 0; seg < 4; seg++) begin
         s  = 15'($urandom);
         nf = $urandom_range(2, 4);
         load_seed(s);
         fseed_q.delete();
         repeat (nf) fseed_q.push_back(s);
         enable = 1'b1;
         src_q.delete();
         repeat (FL * nf) src_q.push_back(8'($urandom));
         acc0 = acc_q.size();
         cap0 = cap_q.size();
         drive(FL * nf - 2, 1'b1);
         exp_frames += nf;
         drain();
         verify("rand", acc0, cap0);
      end

      // Reset mid-frame with a byte held; afterwards the default seed is back.
      load_seed(15'h1234);
      enable = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h5A;
      out_ready = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_outputs", {21'd0, out_valid, out_data, out_sof, out_eof, in_ready, busy}, 32'd0);
      check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
      exp_frames = 0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      enable = 1'b0;
      rst = 1'b0;
      enable = 1'b1;
      src_q.delete();
      repeat (4) src_q.push_back(8'($urandom));
      fseed_q = '{15'h00A9};
      acc0 = acc_q.size();
      cap0 = cap_q.size();
      drive(1, 1'b0);
      exp_frames++;
      drain();
      verify("post_rst", acc0, cap0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_scrambler_frame_ctrl
